// File: rtl/mux_scan_sequencer_if.sv
`default_nettype none
// mux_scan_sequencer_if: select/sample side of the mux plus the indexed output stream.
// Revision: 1.0
interface mux_scan_sequencer_if #(
  parameter int N     = 16,
  parameter int WIDTH = 4
);
  localparam int SEL_W = $clog2(N);

  logic             start;
  logic [SEL_W-1:0] select_line;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_index;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, mux_y, out_ready,
    input  select_line, out_data, out_index, out_valid, busy, done
  );

  modport slave (
    input  start, mux_y, out_ready,
    output select_line, out_data, out_index, out_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// mux_scan_sequencer: walks an N:1 word mux and streams each sampled word with its index.
// Build option MUX_SCAN_SKIP_EMPTY_EN drops words equal to EMPTY_VAL. Revision: 1.0
module mux_scan_sequencer #(
  parameter int               N         = 16,
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = {WIDTH{1'b1}}
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  mux_scan_sequencer_if.slave bus
);
  localparam int               SEL_W = $clog2(N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);
`ifdef MUX_SCAN_SKIP_EMPTY_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic slot_free;
  logic accept;
  logic empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    index_d   = index_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    slot_free = !valid_q || bus.out_ready;
    accept    = valid_q && bus.out_ready;
    empty     = SKIP_EN && (bus.mux_y == EMPTY_VAL);

    unique case (state_q)
      S_IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Empty words advance without waiting; a held word stays until accepted.
        if (empty || slot_free) begin
          if (!empty) begin
            data_d  = bus.mux_y;
            index_d = sel_q;
            valid_d = 1'b1;
          end else if (accept) begin
            valid_d = 1'b0;
          end
          if (sel_q == LAST) begin
            sel_d   = '0;
            state_d = S_DRAIN;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (accept || !valid_q) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.select_line = sel_q;
  assign bus.out_data    = data_q;
  assign bus.out_index   = index_q;
  assign bus.out_valid   = valid_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
endmodule
`default_nettype wire
